// File: rtl/audio_voice_pkg.sv
// Shared register map, field indices and response codes for the voice bank.
package audio_voice_pkg;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_INC      = 2'd1;
    localparam logic [1:0] REG_AMP      = 2'd2;
    localparam logic [1:0] REG_PHASE    = 2'd3;

    localparam logic [1:0] REG_VERSION  = 2'd0;
    localparam logic [1:0] REG_IRQ_STAT = 2'd1;
    localparam logic [1:0] REG_IRQ_MASK = 2'd2;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_GATE = 1;
    localparam int CTRL_CLR  = 2;

    localparam logic [31:0] VERSION_BASE = 32'h0004_0000;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    function automatic logic [31:0] merge_wstrb(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/voice_phase_acc.sv
// Single voice phase accumulator; clear beats a coincident sample tick.
module voice_phase_acc #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] inc,
    output logic [WIDTH-1:0] phase,
    output logic             wrap
);

    logic [WIDTH:0] sum;

    assign sum  = {1'b0, phase} + {1'b0, inc};
    assign wrap = tick && en && !clr && sum[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= '0;
        else if (clr)
            phase <= '0;
        else if (tick && en)
            phase <= sum[WIDTH-1:0];
    end

endmodule

// File: rtl/audio_voice_axil_bank.sv
// AXI4-Lite register bank for NUM_VOICES phase-accumulating voices.
// Wrap interrupts are built only when AUDIO_VOICE_IRQ_EN is defined.
module audio_voice_axil_bank
    import audio_voice_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int PHASE_WIDTH = 24,
    parameter int AMP_WIDTH   = 16
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic [ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                       S_AXI_AWPROT,
    input  logic                             S_AXI_AWVALID,
    output logic                             S_AXI_AWREADY,
    input  logic [31:0]                      S_AXI_WDATA,
    input  logic [3:0]                       S_AXI_WSTRB,
    input  logic                             S_AXI_WVALID,
    output logic                             S_AXI_WREADY,
    output logic [1:0]                       S_AXI_BRESP,
    output logic                             S_AXI_BVALID,
    input  logic                             S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                       S_AXI_ARPROT,
    input  logic                             S_AXI_ARVALID,
    output logic                             S_AXI_ARREADY,
    output logic [31:0]                      S_AXI_RDATA,
    output logic [1:0]                       S_AXI_RRESP,
    output logic                             S_AXI_RVALID,
    input  logic                             S_AXI_RREADY,
    input  logic                             sample_tick,
    output logic [NUM_VOICES*PHASE_WIDTH-1:0] voice_phase,
    output logic [NUM_VOICES*AMP_WIDTH-1:0]  voice_amp,
    output logic [NUM_VOICES-1:0]            voice_gate,
    output logic                             irq
);

    localparam int IW = ADDR_WIDTH - 4;
    localparam logic [IW-1:0] GLB_IDX = IW'(NUM_VOICES);

    logic                  aw_full, w_full, bvalid_q, rvalid_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           w_data_q, rdata_q, wr_old, wr_data, rd_data;
    logic [3:0]            w_strb_q;
    resp_t                 bresp_q, rresp_q, rd_resp;

    logic [NUM_VOICES-1:0]                  en_q, gate_q, clr_w, wrap_w;
    logic [NUM_VOICES-1:0]                  irq_stat, irq_mask;
    logic [NUM_VOICES-1:0][PHASE_WIDTH-1:0] inc_q, phase_w;
    logic [NUM_VOICES-1:0][AMP_WIDTH-1:0]   amp_q;
    logic                                   irq_q;

    logic          wr_fire, w_glb;
    logic [IW-1:0] w_idx, r_idx;
    logic [1:0]    w_reg, r_reg;

    assign S_AXI_AWREADY = !aw_full && !bvalid_q;
    assign S_AXI_WREADY  = !w_full && !bvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = !rvalid_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign voice_phase = phase_w;
    assign voice_amp   = amp_q;
    assign voice_gate  = gate_q;
    assign irq         = irq_q;

    assign wr_fire = aw_full && w_full;
    assign w_idx   = aw_addr_q[ADDR_WIDTH-1:4];
    assign w_reg   = aw_addr_q[3:2];
    assign w_glb   = (w_idx == GLB_IDX);
    assign r_idx   = S_AXI_ARADDR[ADDR_WIDTH-1:4];
    assign r_reg   = S_AXI_ARADDR[3:2];

    // Merge byte strobes against the current value; W1C status merges against 0.
    always_comb begin
        wr_old = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_idx == IW'(v)) begin
                case (w_reg)
                    REG_CTRL: wr_old = 32'({gate_q[v], en_q[v]});
                    REG_INC:  wr_old = 32'(inc_q[v]);
                    REG_AMP:  wr_old = 32'(amp_q[v]);
                    default:  ;
                endcase
            end
        end
        if (w_glb && w_reg == REG_IRQ_MASK)
            wr_old = 32'(irq_mask);
        wr_data = merge_wstrb(wr_old, w_data_q, w_strb_q);
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (r_idx > GLB_IDX) begin
            rd_resp = RESP_SLVERR;
        end else if (r_idx == GLB_IDX) begin
            case (r_reg)
                REG_VERSION:  rd_data = VERSION_BASE | 32'(NUM_VOICES);
                REG_IRQ_STAT: rd_data = 32'(irq_stat);
                REG_IRQ_MASK: rd_data = 32'(irq_mask);
                default:      ;
            endcase
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_idx == IW'(v)) begin
                case (r_reg)
                    REG_CTRL:  rd_data = 32'({gate_q[v], en_q[v]});
                    REG_INC:   rd_data = 32'(inc_q[v]);
                    REG_AMP:   rd_data = 32'(amp_q[v]);
                    REG_PHASE: rd_data = 32'(phase_w[v]);
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_full   <= 1'b1;
                aw_addr_q <= S_AXI_AWADDR;
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_full   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (wr_fire) begin
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= (w_idx > GLB_IDX) ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_resp;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            en_q   <= '0;
            gate_q <= '0;
            inc_q  <= '0;
            amp_q  <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (wr_fire && w_idx == IW'(v)) begin
                    case (w_reg)
                        REG_CTRL: begin
                            en_q[v]   <= wr_data[CTRL_EN];
                            gate_q[v] <= wr_data[CTRL_GATE];
                        end
                        REG_INC: inc_q[v] <= wr_data[PHASE_WIDTH-1:0];
                        REG_AMP: amp_q[v] <= wr_data[AMP_WIDTH-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign clr_w[v] = wr_fire && w_idx == IW'(v) &&
                          w_reg == REG_CTRL && wr_data[CTRL_CLR];

        voice_phase_acc #(.WIDTH(PHASE_WIDTH)) u_acc (
            .clk   (ACLK),
            .rst_n (ARESETN),
            .tick  (sample_tick),
            .en    (en_q[v]),
            .clr   (clr_w[v]),
            .inc   (inc_q[v]),
            .phase (phase_w[v]),
            .wrap  (wrap_w[v])
        );
    end

`ifdef AUDIO_VOICE_IRQ_EN
    logic [NUM_VOICES-1:0] stat_clr;

    assign stat_clr = (wr_fire && w_glb && w_reg == REG_IRQ_STAT) ?
                      wr_data[NUM_VOICES-1:0] : '0;

    // A wrap landing on the clear cycle survives the clear.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_stat <= '0;
            irq_mask <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_stat <= (irq_stat & ~stat_clr) | wrap_w;
            if (wr_fire && w_glb && w_reg == REG_IRQ_MASK)
                irq_mask <= wr_data[NUM_VOICES-1:0];
            irq_q <= |(irq_stat & irq_mask);
        end
    end
`else
    logic unused_wrap;

    assign irq_stat    = '0;
    assign irq_mask    = '0;
    assign irq_q       = 1'b0;
    assign unused_wrap = ^wrap_w;
`endif

    logic unused_bits;

    assign unused_bits = ^{wr_data, S_AXI_AWPROT, S_AXI_ARPROT,
                           aw_addr_q[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_audio_voice_axil_bank.sv
// Directed scoreboard bench for audio_voice_axil_bank (NUM_VOICES=4).
module tb_audio_voice_axil_bank;

`ifdef AUDIO_VOICE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [7:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b1;
    logic [7:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b1;
    logic        sample_tick = 1'b0;
    logic [95:0] voice_phase;
    logic [63:0] voice_amp;
    logic [3:0]  voice_gate;
    logic        irq;

    audio_voice_axil_bank dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .sample_tick(sample_tick), .voice_phase(voice_phase),
        .voice_amp(voice_amp), .voice_gate(voice_gate), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] rq_data[$];
    logic [1:0]  rq_resp[$];
    string       rq_name[$];
    logic [1:0]  bq[$];

    logic [31:0] m_ed;
    logic [1:0]  m_er;
    string       m_nm;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    always @(negedge ACLK) begin
        if (ARESETN && S_AXI_RVALID && S_AXI_RREADY) begin
            if (rq_data.size() == 0) begin
                chk("r_unexpected", 1, 0);
            end else begin
                m_ed = rq_data.pop_front();
                m_er = rq_resp.pop_front();
                m_nm = rq_name.pop_front();
                chk({m_nm, "_rdata"}, S_AXI_RDATA, m_ed);
                chk({m_nm, "_rresp"}, S_AXI_RRESP, m_er);
            end
        end
        if (ARESETN && S_AXI_BVALID && S_AXI_BREADY) begin
            if (bq.size() == 0) chk("b_unexpected", 1, 0);
            else begin
                m_er = bq.pop_front();
                chk("bresp", S_AXI_BRESP, m_er);
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge ACLK); #1 sample_tick = 1'b1;
            @(posedge ACLK); #1 sample_tick = 1'b0;
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] resp);
        bit awd, wd, ah, wh, got;
        awd = 0; wd = 0; got = 0;
        bq.push_back(resp);
        @(posedge ACLK); #1;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 20 && !(awd && wd); i++) begin
            @(negedge ACLK);
            ah = S_AXI_AWVALID && S_AXI_AWREADY;
            wh = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (ah) begin S_AXI_AWVALID = 1'b0; awd = 1; end
            if (wh) begin S_AXI_WVALID = 1'b0; wd = 1; end
        end
        if (!(awd && wd)) begin
            chk("aw_w_timeout", 0, 1);
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID && S_AXI_BREADY) got = 1;
        end
        @(posedge ACLK); #1;
        if (!got) chk("b_timeout", 0, 1);
    endtask

    task automatic axi_read(input string nm, input logic [7:0] a,
                            input logic [31:0] ed, input logic [1:0] er);
        bit ard, hit, got;
        ard = 0; got = 0;
        rq_data.push_back(ed); rq_resp.push_back(er); rq_name.push_back(nm);
        @(posedge ACLK); #1;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20 && !ard; i++) begin
            @(negedge ACLK);
            hit = S_AXI_ARVALID && S_AXI_ARREADY;
            @(posedge ACLK); #1;
            if (hit) begin S_AXI_ARVALID = 1'b0; ard = 1; end
        end
        if (!ard) begin chk("ar_timeout", 0, 1); S_AXI_ARVALID = 1'b0; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID && S_AXI_RREADY) got = 1;
        end
        @(posedge ACLK); #1;
        if (!got) chk("r_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        #1;
        chk("rst_awready", S_AXI_AWREADY, 1);
        chk("rst_wready", S_AXI_WREADY, 1);
        chk("rst_arready", S_AXI_ARREADY, 1);
        chk("rst_bvalid", S_AXI_BVALID, 0);
        chk("rst_rvalid", S_AXI_RVALID, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_outs", {voice_amp, voice_gate, irq}, 0);
        chk("rst_phase", voice_phase[63:0], 0);

        axi_read("version", 8'h40, 32'h0004_0004, 2'b00);
        axi_read("v1_inc_rst", 8'h14, 32'h0, 2'b00);
        axi_read("v2_amp_rst", 8'h28, 32'h0, 2'b00);

        axi_write(8'h14, 32'h100, 4'hF, 2'b00);
        axi_write(8'h10, 32'h1, 4'hF, 2'b00);
        axi_read("v1_ctrl", 8'h10, 32'h1, 2'b00);
        tick_n(3);
        chk("v1_phase", voice_phase[47:24], 24'h300);
        chk("v0_phase_idle", voice_phase[23:0], 24'h0);
        axi_read("v1_phase_reg", 8'h1C, 32'h300, 2'b00);
        axi_write(8'h10, 32'h0, 4'hF, 2'b00);

        axi_write(8'h04, 32'hFFFFF0, 4'hF, 2'b00);
        axi_write(8'h00, 32'h1, 4'hF, 2'b00);
        tick_n(2);
        chk("v0_phase_2t", voice_phase[23:0], 24'hFFFFE0);
        axi_read("irq_stat_wrap", 8'h44, IRQ_ON ? 32'h1 : 32'h0, 2'b00);
        axi_write(8'h44, 32'h1, 4'hF, 2'b00);
        axi_read("irq_stat_clr", 8'h44, 32'h0, 2'b00);
        axi_write(8'h48, 32'h1, 4'hF, 2'b00);
        axi_read("irq_mask", 8'h48, IRQ_ON ? 32'h1 : 32'h0, 2'b00);
        axi_write(8'h04, 32'h30, 4'hF, 2'b00);
        chk("irq_before_wrap", irq, 0);
        tick_n(1);
        chk("v0_phase_wrap", voice_phase[23:0], 24'h10);
        repeat (2) @(posedge ACLK);
        #1 chk("irq_set", irq, IRQ_ON);
        axi_write(8'h44, 32'h1, 4'hF, 2'b00);
        repeat (2) @(posedge ACLK);
        #1 chk("irq_w1c", irq, 0);

        // W leads AW by three cycles, then B is stalled.
        bq.push_back(2'b00);
        S_AXI_BREADY = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_WDATA = 32'h1234; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1 S_AXI_WVALID = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        chk("w_held_wready", S_AXI_WREADY, 0);
        chk("w_held_awready", S_AXI_AWREADY, 1);
        chk("w_held_bvalid", S_AXI_BVALID, 0);
        S_AXI_AWADDR = 8'h28; S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1 S_AXI_AWVALID = 1'b0;
        @(posedge ACLK); #1;
        for (int i = 0; i < 4; i++) begin
            chk("b_stall_bvalid", S_AXI_BVALID, 1);
            chk("b_stall_awready", S_AXI_AWREADY, 0);
            @(posedge ACLK); #1;
        end
        chk("b_stall_amp", voice_amp[47:32], 16'h1234);
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        chk("b_done_bvalid", S_AXI_BVALID, 0);
        axi_read("v2_amp", 8'h28, 32'h1234, 2'b00);

        axi_write(8'h38, 32'hAABBCCDD, 4'b0010, 2'b00);
        axi_read("v3_amp_strb", 8'h38, 32'h0000CC00, 2'b00);
        axi_read("bad_idx_rd", 8'h50, 32'h0, 2'b10);
        axi_write(8'h50, 32'hFFFF_FFFF, 4'hF, 2'b10);
        axi_read("reserved_rd", 8'h4C, 32'h0, 2'b00);
        axi_write(8'h40, 32'h0, 4'hF, 2'b00);
        axi_read("version_ro", 8'h40, 32'h0004_0004, 2'b00);

        // phase_clr lands on the same edge as a sample tick.
        chk("v0_pre_clr", voice_phase[23:0], 24'h10);
        bq.push_back(2'b00);
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 8'h00; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; sample_tick = 1'b1;
        @(posedge ACLK); #1 sample_tick = 1'b0;
        chk("clr_vs_tick", voice_phase[23:0], 24'h0);
        chk("v1_phase_held", voice_phase[47:24], 24'h300);
        repeat (2) @(posedge ACLK);
        axi_read("v0_ctrl_clr_rd0", 8'h00, 32'h1, 2'b00);
        tick_n(1);
        chk("v0_after_clr", voice_phase[23:0], 24'h30);
        axi_write(8'h20, 32'h2, 4'hF, 2'b00);
        chk("gate_v2", voice_gate, 4'b0100);

        // Reset while a read response is waiting.
        S_AXI_RREADY = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_ARADDR = 8'h40; S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1 S_AXI_ARVALID = 1'b0;
        chk("rvalid_pending", S_AXI_RVALID, 1);
        ARESETN = 1'b0;
        #1;
        chk("rst_rvalid_drop", S_AXI_RVALID, 0);
        chk("rst_phase_clr", voice_phase[47:0], 0);
        chk("rst_gate", voice_gate, 0);
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        S_AXI_RREADY = 1'b1;
        axi_read("v0_ctrl_rst", 8'h00, 32'h0, 2'b00);
        axi_read("v3_amp_rst", 8'h38, 32'h0, 2'b00);

        repeat (3) @(posedge ACLK);
        chk("rq_empty", rq_data.size(), 0);
        chk("bq_empty", bq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/audio_voice_axil_bank.md
Name: audio_voice_axil_bank

Overview:
AXI4-Lite slave holding control registers for NUM_VOICES audio voices. Each voice has a phase accumulator that advances on a sample tick. This block succeeds the fixed 4-register AudioVoice peripheral in the AudSynth block design. It drives per-voice phase, amplitude and gate buses to the downstream waveform/mixer logic.

Parameters:
NUM_VOICES, 4, number of voices (1..15)
ADDR_WIDTH, 8, AXI address width; must cover (NUM_VOICES+1)*16 bytes
PHASE_WIDTH, 24, accumulator width (<=32)
AMP_WIDTH, 16, amplitude width (<=32)

Ports:
ACLK  in  1  clock
ARESETN  in  1  async active-low reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_WIDTH/3/1/1  read address
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data
sample_tick  in  1  one-cycle strobe at sample rate
voice_phase  out  NUM_VOICES*PHASE_WIDTH  current phase, voice 0 in LSBs
voice_amp  out  NUM_VOICES*AMP_WIDTH  amplitude register per voice
voice_gate  out  NUM_VOICES  CTRL.gate per voice
irq  out  1  interrupt (see Optional Feature)

Behaviour:
- Decode: idx = addr[ADDR_WIDTH-1:4], reg = addr[3:2]. Writes ignore addr[1:0]; reads return 32-bit aligned data.
- Voice regs (idx < NUM_VOICES):
  - 0x0 CTRL: bit0 enable, bit1 gate, bit2 phase_clr (write-1 self-clearing, reads 0).
  - 0x4 PHASE_INC: [PHASE_WIDTH-1:0].
  - 0x8 AMP: [AMP_WIDTH-1:0].
  - 0xC PHASE: read-only; writes are ignored with OKAY.
- Global regs (idx == NUM_VOICES):
  - 0x0 VERSION: read-only, 32'h0004_0000 | NUM_VOICES.
  - 0x4 IRQ_STATUS: W1C.
  - 0x8 IRQ_MASK.
  - 0xC reserved: reads 0, writes ignored, OKAY.
- idx > NUM_VOICES: SLVERR; reads return 0; no state change.
- Unused register bits read 0. WSTRB applies per byte.
- Write handshake:
  - AWREADY and WREADY are high while the respective channel is not yet captured and no B is pending. AW and W may arrive in either order or together.
  - On the cycle after both are held: register update and BVALID=1.
  - BVALID is held until BREADY. Only one write outstanding at a time.
- Read handshake:
  - ARREADY is high when RVALID=0.
  - RDATA/RRESP/RVALID are registered and appear 1 cycle after the AR handshake, held until RREADY.
- Reads and writes are independent. A same-cycle read and write to the same register returns the old value.
- Accumulator, on sample_tick: each voice with enable=1 does phase <= (phase + inc) mod 2^PHASE_WIDTH. Disabled voices hold phase.
- phase_clr write sets phase to 0. This wins over a simultaneous tick.
- Reset values: all registers 0, phases 0; AWREADY/WREADY/ARREADY 1; BVALID/RVALID 0; BRESP/RRESP 0; RDATA 0; outputs 0; irq 0.
- ARESETN asserted mid-transaction aborts it. Nothing is replayed after reset.

Optional Feature:
AUDIO_VOICE_IRQ_EN:
- Defined:
  - A phase wrap (carry out of the add) on an enabled voice sets IRQ_STATUS[v].
  - Writing 1 to a bit clears it; a set on the same cycle as the clear wins.
  - irq = |(IRQ_STATUS & IRQ_MASK), registered, so it lags the status change by 1 cycle.
- Undefined: IRQ_STATUS and IRQ_MASK read 0, writes are ignored, irq is tied 0.

Decomposition:
- Package audio_voice_pkg: register offset constants, CTRL bit indices, VERSION constant, resp_t codes (OKAY=2'b00, SLVERR=2'b10).
- Sub-module voice_phase_acc: one accumulator with enable, clr, tick, inc and wrap output, instantiated NUM_VOICES times by generate.

Test Plan:
- Reset, then read 0x40 with NUM_VOICES=4 -> 32'h0004_0004 OKAY. Read any voice reg -> 0.
- Write voice1 PHASE_INC=0x100 and CTRL=0x1, then 3 sample_ticks -> voice_phase[47:24]=0x300. voice0 phase stays 0.
- PHASE_INC=0xFFFFF0 with 2 ticks -> phase 0xFFFFE0. With IRQ_EN and MASK=0x1 on voice0, a third tick after PHASE_INC=0x30 wraps and asserts irq. W1C of 0x1 to 0x44 deasserts it.
- Send W 3 cycles before AW, hold BREADY low for 4 cycles -> single update, BVALID held, no second AW accepted until B completes.
- WSTRB=4'b0010 write of 0xAABBCCDD to AMP -> AMP=0x0000CC00. Read 0x50 -> SLVERR, RDATA=0.
- phase_clr written in the same cycle as sample_tick -> phase 0. Assert ARESETN low during a pending RVALID -> RVALID drops immediately.
